// File: rtl/aon_pwr_pkg.sv
// ============================================================================
// Module   : aon_pwr_pkg
// Brief    : Shared constants and types for the always-on power register bank:
//            register offsets, DELAY field positions, LOCK bit index and the
//            per-domain delay record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aon_pwr_pkg;

    // Register byte offsets
    localparam int unsigned c_ADDR_SLEEP_REQ  = 32'h00;
    localparam int unsigned c_ADDR_PWRGATE_EN = 32'h04;
    localparam int unsigned c_ADDR_PWR_STATUS = 32'h08;
    localparam int unsigned c_ADDR_WAKE_EVT   = 32'h0C;
    localparam int unsigned c_ADDR_IRQ_EN     = 32'h10;
    localparam int unsigned c_ADDR_LOCK       = 32'h14;
    localparam int unsigned c_ADDR_WKEN_BASE  = 32'h20;
    localparam int unsigned c_ADDR_DELAY_BASE = 32'h40;

    // Bit index of the lock flag inside LOCK
    localparam int unsigned c_LOCK_BIT = 0;

    // DELAY register field positions
    localparam int unsigned c_DLY_ON_SEQ_LSB  = 0;
    localparam int unsigned c_DLY_OFF_SEQ_LSB = 4;
    localparam int unsigned c_DLY_ON_LSB      = 8;
    localparam int unsigned c_DLY_OFF_LSB     = 16;
    localparam int unsigned c_DLY_W           = 24;

    // Per-domain delay record; packed order mirrors the DELAY register layout
    typedef struct packed {
        logic [7:0] off_delay;
        logic [7:0] on_delay;
        logic [3:0] off_seq;
        logic [3:0] on_seq;
    } delay_t;

    // Split a raw DELAY write value into its fields
    function automatic delay_t f_unpack_delay(input logic [c_DLY_W-1:0] raw);
        delay_t d;
        d.on_seq    = raw[c_DLY_ON_SEQ_LSB  +: 4];
        d.off_seq   = raw[c_DLY_OFF_SEQ_LSB +: 4];
        d.on_delay  = raw[c_DLY_ON_LSB      +: 8];
        d.off_delay = raw[c_DLY_OFF_LSB     +: 8];
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aon_wake_evt.sv
// ============================================================================
// Module   : aon_wake_evt
// Brief    : Sticky write-1-to-clear wakeup event bank with a registered,
//            enable-masked interrupt reduction. Set has priority over clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aon_wake_evt #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] set_i,
    input  logic [W-1:0] clr_i,
    input  logic [W-1:0] irq_en_i,
    output logic [W-1:0] evt_o,
    output logic         irq_o
);

    logic [W-1:0] evt_q;
    logic [W-1:0] evt_d;
    logic         irq_q;

    // Next event state: clear written-1 bits, then apply new sets on top
    always_comb begin
        evt_d = (evt_q & ~clr_i) | set_i;
    end

    // Event and interrupt registers; irq follows the stored events by one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            irq_q <= |(evt_q & irq_en_i);
        end
    end

    assign evt_o = evt_q;
    assign irq_o = irq_q;

endmodule

`default_nettype wire

// File: rtl/aon_pwr_regbank.sv
// ============================================================================
// Module   : aon_pwr_regbank
// Brief    : Always-on power-controller register bank for N domains with M
//            wakeup sources each. Single-beat bus decode, registered read
//            response, sleep-request auto-clear on domain power-off, sticky
//            wakeup events with interrupt.
// Options  : AON_RF_LOCK_EN - adds the LOCK register that freezes the
//            configuration registers until reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aon_pwr_regbank
    import aon_pwr_pkg::*;
#(
    parameter int N          = 2,
    parameter int M          = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_aon_clk,
    input  logic                  i_soc_pwr_on_rst,
    input  logic                  slv_o_valid,
    input  logic                  slv_o_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] slv_o_addr,
    input  logic [DATA_WIDTH-1:0] slv_o_wr_data,
    output logic                  slv_i_ready,
    output logic [DATA_WIDTH-1:0] slv_i_rd_data,
    output logic                  slv_i_rd_valid,
    output logic                  slv_i_err,
    input  logic [N-1:0]          fsm_o_d_status,
    input  logic [M*N-1:0]        i_wakeup_src,
    output logic [N-1:0]          rf_o_sleep_req,
    output logic [N-1:0]          rf_o_pwrgate_enable,
    output logic [M*N-1:0]        rf_o_wakeup_enable,
    output logic [4*N-1:0]        rf_o_pwr_on_seq_delay,
    output logic [4*N-1:0]        rf_o_pwr_off_seq_delay,
    output logic [8*N-1:0]        rf_o_pwr_on_delay,
    output logic [8*N-1:0]        rf_o_pwr_off_delay,
    output logic [M*N-1:0]        rf_o_wake_evt,
    output logic                  rf_o_irq
);

    localparam int EVT_W = M * N;

    // Architectural state
    logic                  ready_q;
    logic [N-1:0]          sleep_req_q;
    logic [N-1:0]          sleep_req_d;
    logic [N-1:0]          pwrgate_q;
    logic [N-1:0]          status_q;
    logic [EVT_W-1:0]      irq_en_q;
    logic [EVT_W-1:0]      wakeup_en_q;
    delay_t                delay_q [N];

    // Response registers
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

    // Decode and control
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_hit_sleep;
    logic                  w_hit_pg;
    logic                  w_hit_stat;
    logic                  w_hit_evt;
    logic                  w_hit_irqen;
    logic                  w_hit_lock;
    logic [N-1:0]          w_hit_wken;
    logic [N-1:0]          w_hit_dly;
    logic                  w_mapped;
    logic                  w_protected;
    logic                  w_lock;
    logic                  w_blocked;
    logic                  w_wr_ok;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [N-1:0]          w_fall;
    logic [EVT_W-1:0]      w_evt_set;
    logic [EVT_W-1:0]      w_evt_clr;
    logic [EVT_W-1:0]      w_evt;
    logic                  w_unused;

    // Only the low register fields of the write bus are ever consumed
    assign w_unused = ^slv_o_wr_data;

    assign slv_i_ready = ready_q && !i_soc_pwr_on_rst;
    assign w_acc       = slv_o_valid && slv_i_ready;
    assign w_wr        = w_acc && slv_o_rd0_wr1;
    assign w_rd        = w_acc && !slv_o_rd0_wr1;

    assign w_hit_sleep = (slv_o_addr == ADDR_WIDTH'(c_ADDR_SLEEP_REQ));
    assign w_hit_pg    = (slv_o_addr == ADDR_WIDTH'(c_ADDR_PWRGATE_EN));
    assign w_hit_stat  = (slv_o_addr == ADDR_WIDTH'(c_ADDR_PWR_STATUS));
    assign w_hit_evt   = (slv_o_addr == ADDR_WIDTH'(c_ADDR_WAKE_EVT));
    assign w_hit_irqen = (slv_o_addr == ADDR_WIDTH'(c_ADDR_IRQ_EN));

    for (genvar d = 0; d < N; d++) begin : g_dec
        assign w_hit_wken[d] = (slv_o_addr == ADDR_WIDTH'(c_ADDR_WKEN_BASE  + 32'(4 * d)));
        assign w_hit_dly[d]  = (slv_o_addr == ADDR_WIDTH'(c_ADDR_DELAY_BASE + 32'(4 * d)));
    end

`ifdef AON_RF_LOCK_EN
    logic lock_q;

    assign w_hit_lock = (slv_o_addr == ADDR_WIDTH'(c_ADDR_LOCK));
    assign w_lock     = lock_q;

    // Lock is set-only by software; only reset releases it
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            lock_q <= 1'b0;
        end else if (w_wr_ok && w_hit_lock && slv_o_wr_data[c_LOCK_BIT]) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign w_hit_lock = 1'b0;
    assign w_lock     = 1'b0;
`endif

    assign w_mapped    = w_hit_sleep | w_hit_pg | w_hit_stat | w_hit_evt | w_hit_irqen
                       | w_hit_lock | (|w_hit_wken) | (|w_hit_dly);
    assign w_protected = w_hit_pg | w_hit_irqen | (|w_hit_wken) | (|w_hit_dly);
    assign w_blocked   = w_hit_stat | (w_lock && w_protected);
    assign w_wr_ok     = w_wr && w_mapped && !w_blocked;
    assign w_err       = w_acc && (!w_mapped || (slv_o_rd0_wr1 && w_blocked));

    // A domain that was on last cycle and is off now has just powered down
    assign w_fall = status_q & ~fsm_o_d_status;

    // Sleep request: software write first, then hardware clear wins per bit
    always_comb begin
        sleep_req_d = sleep_req_q;
        if (w_wr_ok && w_hit_sleep) begin
            sleep_req_d = slv_o_wr_data[N-1:0];
        end
        sleep_req_d = sleep_req_d & ~w_fall;
    end

    // Read data mux over pre-update register values; unmapped reads give 0
    always_comb begin
        w_rdata = '0;
        if (w_hit_sleep) w_rdata[N-1:0] = sleep_req_q;
        if (w_hit_pg)    w_rdata[N-1:0] = pwrgate_q;
        if (w_hit_stat)  w_rdata[N-1:0] = status_q;
        if (w_hit_evt)   w_rdata[EVT_W-1:0] = w_evt;
        if (w_hit_irqen) w_rdata[EVT_W-1:0] = irq_en_q;
        if (w_hit_lock)  w_rdata[c_LOCK_BIT] = w_lock;
        for (int d = 0; d < N; d++) begin
            if (w_hit_wken[d]) w_rdata[M-1:0] = wakeup_en_q[d*M +: M];
            if (w_hit_dly[d])  w_rdata[c_DLY_W-1:0] = delay_q[d];
        end
    end

    // Control and configuration registers
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            ready_q     <= 1'b0;
            status_q    <= '0;
            sleep_req_q <= '0;
            pwrgate_q   <= '0;
            irq_en_q    <= '0;
            wakeup_en_q <= '0;
            for (int d = 0; d < N; d++) begin
                delay_q[d] <= '0;
            end
        end else begin
            ready_q     <= 1'b1;
            status_q    <= fsm_o_d_status;
            sleep_req_q <= sleep_req_d;
            if (w_wr_ok && w_hit_pg) begin
                pwrgate_q <= slv_o_wr_data[N-1:0];
            end
            if (w_wr_ok && w_hit_irqen) begin
                irq_en_q <= slv_o_wr_data[EVT_W-1:0];
            end
            for (int d = 0; d < N; d++) begin
                if (w_wr_ok && w_hit_wken[d]) begin
                    wakeup_en_q[d*M +: M] <= slv_o_wr_data[M-1:0];
                end
                if (w_wr_ok && w_hit_dly[d]) begin
                    delay_q[d] <= f_unpack_delay(slv_o_wr_data[c_DLY_W-1:0]);
                end
            end
        end
    end

    // Bus response: one-cycle read/err pulses, data forced to 0 when idle
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= w_rd;
            rd_data_q  <= w_rd ? w_rdata : '0;
            err_q      <= w_err;
        end
    end

    assign w_evt_set = i_wakeup_src & wakeup_en_q;
    assign w_evt_clr = (w_wr_ok && w_hit_evt) ? slv_o_wr_data[EVT_W-1:0] : '0;

    aon_wake_evt #(
        .W (EVT_W)
    ) u_wake_evt (
        .clk_i    (i_aon_clk),
        .rst_i    (i_soc_pwr_on_rst),
        .set_i    (w_evt_set),
        .clr_i    (w_evt_clr),
        .irq_en_i (irq_en_q),
        .evt_o    (w_evt),
        .irq_o    (rf_o_irq)
    );

    for (genvar d = 0; d < N; d++) begin : g_out
        assign rf_o_pwr_on_seq_delay [d*4 +: 4] = delay_q[d].on_seq;
        assign rf_o_pwr_off_seq_delay[d*4 +: 4] = delay_q[d].off_seq;
        assign rf_o_pwr_on_delay     [d*8 +: 8] = delay_q[d].on_delay;
        assign rf_o_pwr_off_delay    [d*8 +: 8] = delay_q[d].off_delay;
    end

    assign rf_o_sleep_req      = sleep_req_q;
    assign rf_o_pwrgate_enable = pwrgate_q;
    assign rf_o_wakeup_enable  = wakeup_en_q;
    assign rf_o_wake_evt       = w_evt;
    assign slv_i_rd_valid      = rd_valid_q;
    assign slv_i_rd_data       = rd_data_q;
    assign slv_i_err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_aon_pwr_regbank.sv
// ============================================================================
// Module   : tb_aon_pwr_regbank
// Brief    : Self-checking bench for aon_pwr_regbank (N=2, M=3): table of
//            register transactions plus directed multi-cycle sequences.
//            Lock checks are compiled in with AON_RF_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aon_pwr_regbank;

    localparam int N  = 2;
    localparam int M  = 3;
    localparam int DW = 32;
    localparam int AW = 8;

`ifdef AON_RF_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic            rw = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   wdata = '0;
    logic            ready;
    logic [DW-1:0]   rdata;
    logic            rd_valid;
    logic            err;
    logic [N-1:0]    fsm_status = '0;
    logic [M*N-1:0]  wake_src = '0;
    logic [N-1:0]    sleep_req;
    logic [N-1:0]    pwrgate;
    logic [M*N-1:0]  wake_en;
    logic [4*N-1:0]  on_seq;
    logic [4*N-1:0]  off_seq;
    logic [8*N-1:0]  on_dly;
    logic [8*N-1:0]  off_dly;
    logic [M*N-1:0]  wake_evt;
    logic            irq;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    aon_pwr_regbank #(
        .N          (N),
        .M          (M),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_aon_clk              (clk),
        .i_soc_pwr_on_rst       (rst),
        .slv_o_valid            (valid),
        .slv_o_rd0_wr1          (rw),
        .slv_o_addr             (addr),
        .slv_o_wr_data          (wdata),
        .slv_i_ready            (ready),
        .slv_i_rd_data          (rdata),
        .slv_i_rd_valid         (rd_valid),
        .slv_i_err              (err),
        .fsm_o_d_status         (fsm_status),
        .i_wakeup_src           (wake_src),
        .rf_o_sleep_req         (sleep_req),
        .rf_o_pwrgate_enable    (pwrgate),
        .rf_o_wakeup_enable     (wake_en),
        .rf_o_pwr_on_seq_delay  (on_seq),
        .rf_o_pwr_off_seq_delay (off_seq),
        .rf_o_pwr_on_delay      (on_dly),
        .rf_o_pwr_off_delay     (off_dly),
        .rf_o_wake_evt          (wake_evt),
        .rf_o_irq               (irq)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One accepted transaction; outputs sampled 1 ns after the accepting edge
    task automatic txn(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic rv, output logic er);
        @(posedge clk); #1;
        valid = 1'b1; rw = wr; addr = a; wdata = wd;
        @(posedge clk); #1;
        valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        rd = rdata; rv = rd_valid; er = err;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rv;
        logic        er;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", 32'(ready), 32'h0);
        chk("rd_valid_in_reset", 32'(rd_valid), 32'h0);
        chk("sleep_req_reset", 32'(sleep_req), 32'h0);
        chk("irq_reset", 32'(irq), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(ready), 32'h0);
        @(posedge clk); #1;
        chk("ready_up", 32'(ready), 32'h1);

        // ---------------- register table ----------------
        vecs.push_back('{0, 8'h00, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h04, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h08, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h0C, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h10, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h14, 32'h0, 32'h0, !LOCK_EN});
        vecs.push_back('{0, 8'h20, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h24, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h40, 32'h0, 32'h0, 0});
        vecs.push_back('{0, 8'h44, 32'h0, 32'h0, 0});
        vecs.push_back('{1, 8'h44, 32'h00A5_3C21, 32'h0, 0});
        vecs.push_back('{0, 8'h44, 32'h0, 32'h00A5_3C21, 0});
        vecs.push_back('{1, 8'h04, 32'hFFFF_FFFF, 32'h0, 0});
        vecs.push_back('{0, 8'h04, 32'h0, 32'h0000_0003, 0});
        vecs.push_back('{0, 8'h30, 32'h0, 32'h0, 1});
        vecs.push_back('{1, 8'h08, 32'h0000_00FF, 32'h0, 1});
        vecs.push_back('{0, 8'h08, 32'h0, 32'h0, 0});
        vecs.push_back('{1, 8'h10, 32'hFFFF_FFFF, 32'h0, 0});
        vecs.push_back('{0, 8'h10, 32'h0, 32'h0000_003F, 0});
        vecs.push_back('{1, 8'h20, 32'h0000_00FF, 32'h0, 0});
        vecs.push_back('{0, 8'h20, 32'h0, 32'h0000_0007, 0});
        vecs.push_back('{0, 8'h28, 32'h0, 32'h0, 1});
        vecs.push_back('{0, 8'h02, 32'h0, 32'h0, 1});
        vecs.push_back('{1, 8'h48, 32'h1234_5678, 32'h0, 1});

        foreach (vecs[i]) begin
            txn(vecs[i].wr, vecs[i].a, vecs[i].wd, rd, rv, er);
            chk($sformatf("v%0d_rd_valid@%02h", i, vecs[i].a), 32'(rv), 32'(!vecs[i].wr));
            chk($sformatf("v%0d_rd_data@%02h",  i, vecs[i].a), rd, vecs[i].exp_data);
            chk($sformatf("v%0d_err@%02h",      i, vecs[i].a), 32'(er), 32'(vecs[i].exp_err));
        end

        // Read response lasts exactly one cycle
        @(posedge clk); #1;
        chk("rd_valid_one_cycle", 32'(rd_valid), 32'h0);
        chk("rd_data_idle_zero", rdata, 32'h0);

        // DELAY[1] fields on the outputs, domain 0 untouched
        chk("on_seq_out",  32'(on_seq),  32'h0000_0010);
        chk("off_seq_out", 32'(off_seq), 32'h0000_0020);
        chk("on_dly_out",  32'(on_dly),  32'h0000_3C00);
        chk("off_dly_out", 32'(off_dly), 32'h0000_A500);
        chk("pwrgate_out", 32'(pwrgate), 32'h0000_0003);

        // ---------------- wakeup events ----------------
        txn(1'b1, 8'h20, 32'h2, rd, rv, er);
        txn(1'b1, 8'h10, 32'h2, rd, rv, er);
        chk("wake_en_out", 32'(wake_en), 32'h0000_0002);
        @(posedge clk); #1;
        wake_src = 6'h03;
        @(posedge clk); #1;
        wake_src = 6'h00;
        chk("wake_evt_set", 32'(wake_evt), 32'h2);
        chk("irq_lag", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'h1);
        txn(1'b0, 8'h0C, 32'h0, rd, rv, er);
        chk("wake_evt_read", rd, 32'h2);
        // W1C together with a fresh set of the same bit: set wins
        @(posedge clk); #1;
        valid = 1'b1; rw = 1'b1; addr = 8'h0C; wdata = 32'h2; wake_src = 6'h02;
        @(posedge clk); #1;
        valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0; wake_src = 6'h00;
        chk("w1c_vs_set", 32'(wake_evt), 32'h2);
        chk("w1c_vs_set_err", 32'(err), 32'h0);
        txn(1'b1, 8'h0C, 32'h2, rd, rv, er);
        chk("w1c_clear", 32'(wake_evt), 32'h0);
        @(posedge clk); #1;
        chk("irq_clear", 32'(irq), 32'h0);

        // ---------------- sleep auto-clear ----------------
        @(posedge clk); #1;
        fsm_status = 2'b11;
        repeat (2) @(posedge clk);
        txn(1'b0, 8'h08, 32'h0, rd, rv, er);
        chk("pwr_status_read", rd, 32'h3);
        txn(1'b1, 8'h00, 32'h3, rd, rv, er);
        chk("sleep_req_set", 32'(sleep_req), 32'h3);
        @(posedge clk); #1;
        fsm_status = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        chk("sleep_autoclear", 32'(sleep_req), 32'h2);
        // Hardware clear beats a same-cycle software set of bit 0 only
        fsm_status = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        valid = 1'b1; rw = 1'b1; addr = 8'h00; wdata = 32'h3; fsm_status = 2'b10;
        @(posedge clk); #1;
        valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        chk("sleep_hw_beats_sw", 32'(sleep_req), 32'h2);

        // ---------------- reset mid-transaction ----------------
        fsm_status = 2'b00;
        @(posedge clk); #1;
        valid = 1'b1; rw = 1'b0; addr = 8'h30; rst = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; addr = '0;
        chk("rst_drop_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_drop_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        chk("rst_err_later", 32'(err), 32'h0);
        chk("rst_pwrgate", 32'(pwrgate), 32'h0);
        chk("rst_wake_en", 32'(wake_en), 32'h0);
        chk("rst_on_dly", 32'(on_dly), 32'h0);
        chk("rst_sleep", 32'(sleep_req), 32'h0);
        rst = 1'b0;
        txn(1'b0, 8'h44, 32'h0, rd, rv, er);
        chk("rst_delay_read", rd, 32'h0);
        chk("rst_delay_rv", 32'(rv), 32'h1);

`ifdef AON_RF_LOCK_EN
        // ---------------- configuration lock ----------------
        txn(1'b1, 8'h14, 32'h1, rd, rv, er);
        chk("lock_set_err", 32'(er), 32'h0);
        txn(1'b0, 8'h14, 32'h0, rd, rv, er);
        chk("lock_read", rd, 32'h1);
        txn(1'b1, 8'h04, 32'h3, rd, rv, er);
        chk("locked_wr_err", 32'(er), 32'h1);
        chk("locked_pwrgate", 32'(pwrgate), 32'h0);
        txn(1'b1, 8'h40, 32'h00FF_FFFF, rd, rv, er);
        chk("locked_dly_err", 32'(er), 32'h1);
        chk("locked_dly_out", 32'(on_seq), 32'h0);
        txn(1'b1, 8'h00, 32'h1, rd, rv, er);
        chk("locked_sleep_err", 32'(er), 32'h0);
        chk("locked_sleep_ok", 32'(sleep_req), 32'h1);
        do_reset();
        txn(1'b0, 8'h14, 32'h0, rd, rv, er);
        chk("lock_reset", rd, 32'h0);
        txn(1'b1, 8'h04, 32'h3, rd, rv, er);
        chk("unlocked_pwrgate", 32'(pwrgate), 32'h3);
`else
        do_reset();
        txn(1'b1, 8'h14, 32'h1, rd, rv, er);
        chk("nolock_wr_err", 32'(er), 32'h1);
        txn(1'b1, 8'h04, 32'h3, rd, rv, er);
        chk("nolock_pwrgate", 32'(pwrgate), 32'h3);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

`default_nettype wire
